// File: rtl/pipeline_pkg.sv
// pipeline_pkg: inter-stage bundle types, widths and ResultSrc encodings
package pipeline_pkg;
    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic [2:0] addressing_control;
    } ex_mem_ctrl_t;
    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [4:0]  rd;
        logic [31:0] pc_plus4;
    } ex_mem_data_t;
    localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
    localparam int EX_MEM_DATA_W = $bits(ex_mem_data_t);
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one valid/ctrl/data register; ctrl is zero whenever the slot is empty
module pipe_slot #(
    parameter int CTRL_W = 7,
    parameter int DATA_W = 101
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);
    // data is deliberately left alone on clear to avoid needless toggling
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= ld_ctrl;
            data  <= ld_data;
        end
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline register with optional skid slot,
// flush and saturating stall counter
module pipe_stage_reg
    import pipeline_pkg::*;
#(
    parameter int CTRL_W = EX_MEM_CTRL_W,
    parameter int DATA_W = EX_MEM_DATA_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_count
);
    logic              in_xfer, out_xfer, main_load, main_clr;
    logic [CTRL_W-1:0] main_ld_ctrl;
    logic [DATA_W-1:0] main_ld_data;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign main_clr = flush || (out_xfer && !main_load);

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_valid, skid_load, skid_clr;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;
            // in_ready depends only on the skid flop, never on out_ready
            assign in_ready     = !skid_valid && !rst;
            assign main_load    = skid_valid ? out_xfer : in_xfer && (!out_valid || out_xfer);
            assign main_ld_ctrl = skid_valid ? skid_ctrl : in_ctrl;
            assign main_ld_data = skid_valid ? skid_data : in_data;
            assign skid_load    = in_xfer && out_valid && !out_xfer;
            assign skid_clr     = flush || (out_xfer && skid_valid);
            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk(clk), .rst(rst), .clr(skid_clr), .load(skid_load),
                .ld_ctrl(in_ctrl), .ld_data(in_data),
                .valid(skid_valid), .ctrl(skid_ctrl), .data(skid_data)
            );
        end else begin : g_single
            assign in_ready     = (out_ready || !out_valid) && !rst;
            assign main_load    = in_xfer;
            assign main_ld_ctrl = in_ctrl;
            assign main_ld_data = in_data;
        end
    endgenerate

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk(clk), .rst(rst), .clr(main_clr), .load(main_load),
        .ld_ctrl(main_ld_ctrl), .ld_data(main_ld_data),
        .valid(out_valid), .ctrl(out_ctrl), .data(out_data)
    );

    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= '0;
        else if (out_valid && !out_ready && stall_count != {CNT_W{1'b1}})
            stall_count <= stall_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of skid, single-register and small-counter variants
module tb_pipe_stage_reg;
    logic         clk = 1'b0;
    logic         rst, flush, in_valid, out_ready;
    logic [6:0]   in_ctrl;
    logic [100:0] in_data;
    logic         rdy1, ov1, rdy0, ov0, rdy4, ov4;
    logic [6:0]   oc1, oc0, oc4;
    logic [100:0] od1, od0, od4;
    logic [15:0]  sc1, sc0;
    logic [3:0]   sc4;
    int           n_tests = 0;
    int           n_fail  = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.SKID(1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov1), .out_ready(out_ready),
        .out_ctrl(oc1), .out_data(od1), .stall_count(sc1)
    );
    pipe_stage_reg #(.SKID(0)) u_single (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov0), .out_ready(out_ready),
        .out_ctrl(oc0), .out_data(od0), .stall_count(sc0)
    );
    pipe_stage_reg #(.SKID(1), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy4),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov4), .out_ready(out_ready),
        .out_ctrl(oc4), .out_data(od4), .stall_count(sc4)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] c, input logic [100:0] d, input logic r);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 7'h0, '0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        drive(1'b1, 7'h11, 101'hAA, 1'b0);
        tick();
        tick();
        check("rst_out_valid", ov1, 0);
        check("rst_out_ctrl", oc1, 0);
        check("rst_out_data", od1, 0);
        check("rst_stall", sc1, 0);
        check("rst_in_ready", rdy1, 0);
        check("rst_in_ready_s0", rdy0, 0);
        rst = 1'b0;
        drive(1'b0, 7'h0, '0, 1'b0);
        check("post_rst_in_ready", rdy1, 1);
        check("post_rst_in_ready_s0", rdy0, 1);

        // streaming: every entry appears exactly one cycle after acceptance
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 7'(i), 101'(i), 1'b1);
            tick();
            check($sformatf("stream_v%0d", i), ov1, 1);
            check($sformatf("stream_d%0d", i), od1, i);
            check($sformatf("stream_c%0d", i), oc1, i);
            check($sformatf("stream_s0_d%0d", i), od0, i);
        end
        drive(1'b0, 7'h0, '0, 1'b1);
        tick();
        check("stream_end_v", ov1, 0);
        check("stream_end_ctrl", oc1, 0);
        check("stream_end_v_s0", ov0, 0);

        // single-cycle stall
        do_reset();
        drive(1'b1, 7'h1, 101'h11, 1'b1);
        tick();
        drive(1'b1, 7'h1, 101'h12, 1'b0);
        check("stall1_in_ready", rdy1, 1);
        check("stall1_in_ready_s0", rdy0, 0);
        tick();
        check("stall1_count", sc1, 1);
        check("stall1_hold", od1, 101'h11);
        drive(1'b0, 7'h0, '0, 1'b1);
        tick();
        check("stall1_next", od1, 101'h12);
        check("stall1_next_v", ov1, 1);
        tick();
        check("stall1_nodup", ov1, 0);

        // SKID=0 accepts while its entry drains
        do_reset();
        drive(1'b1, 7'h2, 101'h15, 1'b1);
        tick();
        check("s0_full_ready", rdy0, 1);

        // full and drain
        do_reset();
        drive(1'b1, 7'h3, 101'h21, 1'b0);
        tick();
        drive(1'b1, 7'h3, 101'h22, 1'b0);
        check("full_second_ready", rdy1, 1);
        tick();
        drive(1'b1, 7'h3, 101'h23, 1'b0);
        check("full_in_ready", rdy1, 0);
        drive(1'b0, 7'h0, '0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check("full_stall", sc1, 5);
        check("full_head", od1, 101'h21);
        check("full_ready_held", rdy1, 0);
        drive(1'b0, 7'h0, '0, 1'b1);
        check("drain_ready_reg", rdy1, 0);
        tick();
        check("drain_d1", od1, 101'h22);
        check("drain_ready", rdy1, 1);
        tick();
        check("drain_empty", ov1, 0);

        // flush collision on a full stage
        do_reset();
        drive(1'b1, 7'h7F, 101'h31, 1'b0);
        tick();
        drive(1'b1, 7'h7F, 101'h32, 1'b0);
        tick();
        check("flush_full_ctrl", oc1, 7'h7F);
        flush = 1'b1;
        drive(1'b1, 7'h7F, 101'h33, 1'b0);
        tick();
        flush = 1'b0;
        check("flush_v", ov1, 0);
        check("flush_ctrl", oc1, 0);
        drive(1'b0, 7'h0, '0, 1'b1);
        tick();
        check("flush_no_in", ov1, 0);

        // flush drops a real input transfer
        drive(1'b1, 7'h41, 101'h41, 1'b0);
        tick();
        flush = 1'b1;
        drive(1'b1, 7'h42, 101'h42, 1'b0);
        check("flush1_ready", rdy1, 1);
        tick();
        flush = 1'b0;
        drive(1'b0, 7'h0, '0, 1'b1);
        check("flush1_v", ov1, 0);
        check("flush1_ctrl_s0", oc0, 0);
        tick();
        check("flush1_dropped", ov1, 0);

        // saturation
        do_reset();
        drive(1'b1, 7'h5, 101'h51, 1'b0);
        tick();
        drive(1'b0, 7'h0, '0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        check("sat_cnt4", sc4, 15);
        check("sat_cnt16", sc1, 20);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("sat_after_flush", sc4, 15);
        check("flush_keeps_cnt16", sc1, 21);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("sat_rst", sc4, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline-stage register with valid/ready handshake, optional two-entry skid buffer, synchronous flush, control-field bubble zeroing and a saturating stall counter. It is the generic replacement for the fixed inter-stage registers: instantiated with the EX→MEM bundle, it allows the memory stage to back-pressure execute on a cache miss without dropping or duplicating instructions.

## Interface
- CTRL_W, default 7: width of control bundle (forced to 0 whenever the entry is invalid; 7 = RegWrite, ResultSrc[1:0], MemWrite, AddressingControl[2:0])
- DATA_W, default 101: width of data bundle (ALUResult, WriteData, Rd, PCPlus4)
- SKID, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
- CNT_W, default 16: stall counter width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- flush  in  1  discard all held entries (branch mispredict)
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  entry present at output
- out_ready  in  1  downstream accepts this cycle
- out_ctrl  out  CTRL_W  control bundle, 0 when out_valid=0
- out_data  out  DATA_W  data bundle, don't-care when out_valid=0
- stall_count  out  CNT_W  cycles with out_valid && !out_ready, saturating

## Operation
- Transfer in: in_valid && in_ready at posedge. Transfer out: out_valid && out_ready at posedge.
- SKID=1: main slot (drives outputs) + skid slot. in_ready = !skid_valid, from a flop. Accepted entry goes to main if main is empty or drains this cycle, else to skid. When main drains and skid is full, skid moves to main. Strict FIFO order; capacity 2.
- SKID=0: one slot; in_ready = out_ready || !out_valid (combinational from out_ready).
- Bubble rule: any slot whose valid is 0 holds ctrl = 0; data is left unchanged (no reset or clear of data on bubble, saving power).
- flush: at next posedge both valids cleared and both ctrl fields zeroed. Flush overrides a simultaneous input transfer, which is dropped. A simultaneous output transfer still counts as delivered downstream.
- stall_count: increments by 1 each cycle out_valid && !out_ready, holds at 2^CNT_W−1, cleared only by rst. Flush does not clear it.
- rst: has priority over flush. All valids 0, all ctrl 0, data 0, stall_count 0.

## Timing
- Reset values: out_valid 0, out_ctrl 0, out_data 0, stall_count 0. in_ready 0 while rst high, 1 in the first cycle after.
- Latency: 1 cycle from in transfer to out_valid. Throughput 1 per cycle with out_ready held high.
- SKID=1 back-pressure: out_ready low for one cycle costs no upstream throughput. in_ready drops the cycle after the skid slot fills and rises the cycle after the skid slot drains.
- No combinational path in→out in either mode. SKID=1 also has no out_ready→in_ready path.
- Simultaneous transfer in and out on a full SKID=1 stage cannot occur (in_ready=0). On one entry, in and out transfers together keep occupancy 1.

## Structure
- Shared package pipeline_pkg: ex_mem_ctrl_t and ex_mem_data_t packed structs and their widths (CTRL_W/DATA_W derived via $bits), plus the ResultSrc encodings. The same package later holds the IF/ID, ID/EX and MEM/WB bundles.
- One natural sub-module: pipe_slot (valid + ctrl + data register with load/clear and the bubble-zeroing rule), instantiated once or twice depending on SKID.
- Counter inline; no FSM beyond occupancy {EMPTY, ONE, TWO} derived from the two valids.

## Test plan
- Reset, SKID=1: hold rst 2 cycles with in_valid=1 → out_valid=0, out_ctrl=0, stall_count=0, in_ready=0. First cycle after rst, in_ready=1.
- Streaming: 8 entries, data 0x1..0x8, out_ready=1 → outputs 0x1..0x8 in order, each 1 cycle after acceptance, with no gaps.
- Single-cycle stall: out_ready=0 for 1 cycle during a stream, SKID=1 → in_ready stays 1, no entry lost or duplicated, stall_count=1. With SKID=0, in_ready=0 that same cycle.
- Full and drain: out_ready=0 for 5 cycles → 2 entries held, in_ready=0 from the cycle after the second accept, stall_count=5. Release → the 2 entries exit in order and in_ready returns to 1.
- Flush collision: stage full with ctrl=7'h7F, flush=1 with in_valid=1 → next cycle out_valid=0, out_ctrl=0, and the incoming entry is absent from output.
- Saturation: CNT_W=4, stall for 20 cycles → stall_count holds at 15. Flush leaves it at 15. rst clears it to 0.
